// File: rtl/led_frame_buf.sv
// led_frame_buf: double-buffered 16x16 column store for the LED scanner, bank swap only at column 15
module led_frame_buf #(
  parameter int NCOL = 16,
  parameter int NROW = 16,
  parameter int FCW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [3:0]      wr_addr,
  input  logic [NROW-1:0] wr_data,
  input  logic            wr_commit,
  input  logic [3:0]      col,
  output logic [NROW-1:0] row_data,
  output logic            swap_pending,
  output logic            wr_err,
  output logic            frame_done,
  output logic [FCW-1:0]  frame_cnt
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PEND = 1'b1;
  logic [NROW-1:0] bank [2][NCOL];
  logic            fsel;
  logic [0:0]      state;
  logic            eof;
  logic            swap;
  always_comb begin
    eof = col == 4'd15;
    swap = eof && (state == PEND || wr_commit);
  end
  assign swap_pending = state == PEND;
  // the write targets the pre-swap back bank, so a same-edge write+commit lands in the new front
  always_ff @(posedge clk)
    if (rst) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < NCOL; i++)
          bank[b][i] <= '0;
      fsel <= 1'b0;
      state <= IDLE;
      row_data <= '0;
      wr_err <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (wr_en && state == IDLE) bank[!fsel][wr_addr] <= wr_data;
      row_data <= bank[fsel][col];
      wr_err <= state == PEND && (wr_en || wr_commit);
      frame_done <= eof;
      frame_cnt <= frame_cnt + FCW'(eof);
      fsel <= fsel ^ swap;
      state <= swap ? IDLE : (wr_commit ? PEND : state);
    end
endmodule
